number_checker: RTL and testbench

Response-side checker for the 8-bit `number` stream that a stimulus block drives. It samples `number` on `valid`, tracks a rotating ring-counter reference model, and compares each sample against the value the model predicts. It flags and counts mismatches, captures the first failure, and resynchronises after losing lock. It sits in the testbench/DUT boundary opposite the stimulus generator and is synthesizable so it can also run on silicon.

---
 rtl/number_checker.sv | 154 +++++++++++++++
 tb/tb_number_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/number_checker.sv
// number_checker: response-side checker for a rotating ring-counter stream.
// It samples `number` on `valid` and predicts each next value with a
// rotate-left/right reference model. It flags and counts mismatches,
// captures the first failure, and drops lock after LOST_N consecutive misses.
// When NUMBER_CHECKER_LOG_EN is defined, a simulation-only logger prints
// mismatches, LOST entries and resyncs. It has no effect on logic or outputs.
module number_checker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int LOST_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] number,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] expected,
    output logic             match,
    output logic             mismatch,
    output logic             error,
    output logic             locked,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic [WIDTH-1:0] first_bad,
    output logic [WIDTH-1:0] first_exp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOST  = 2'd2
    } state_t;

    localparam logic [2:0]       LOST_LIMIT = LOST_N[2:0];
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] expected_q;
    logic             match_q;
    logic             mismatch_q;
    logic             error_q;
    logic             locked_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] sample_count_q;
    logic [WIDTH-1:0] first_bad_q;
    logic [WIDTH-1:0] first_exp_q;
    logic [2:0]       miss_q;

    logic [WIDTH-1:0] rot_obs_d;
    logic [WIDTH-1:0] rot_exp_d;
    logic [CNT_W-1:0] err_count_d;
    logic [CNT_W-1:0] sample_count_d;
    logic [2:0]       miss_d;
    logic             hit_d;

    // dir = 1 rotates left, dir = 0 rotates right
    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] x, input logic d);
        return d ? {x[WIDTH-2:0], x[WIDTH-1]} : {x[0], x[WIDTH-1:1]};
    endfunction

    // Candidate next values: reseed from the observation or free-run the model,
    // plus saturating counter increments.
    always_comb begin
        rot_obs_d      = rotate(number, dir);
        rot_exp_d      = rotate(expected_q, dir);
        hit_d          = (number == expected_q);
        err_count_d    = (err_count_q == '1) ? err_count_q : err_count_q + CNT_ONE;
        sample_count_d = (sample_count_q == '1) ? sample_count_q : sample_count_q + CNT_ONE;
        miss_d         = miss_q + 3'd1;
    end

    // Checker FSM with all outputs registered. Load beats valid, and reset beats both.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            expected_q     <= '0;
            match_q        <= 1'b0;
            mismatch_q     <= 1'b0;
            error_q        <= 1'b0;
            locked_q       <= 1'b0;
            err_count_q    <= '0;
            sample_count_q <= '0;
            first_bad_q    <= '0;
            first_exp_q    <= '0;
            miss_q         <= '0;
        end else begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            if (load) begin
                expected_q <= load_value;
                state_q    <= TRACK;
                locked_q   <= 1'b1;
                miss_q     <= '0;
            end else if (valid) begin
                if (state_q != TRACK) begin
                    // Seed from IDLE or resync from LOST; no compare this sample
                    expected_q <= rot_obs_d;
                    state_q    <= TRACK;
                    locked_q   <= 1'b1;
                    miss_q     <= '0;
                end else if (hit_d) begin
                    match_q        <= 1'b1;
                    sample_count_q <= sample_count_d;
                    expected_q     <= rot_obs_d;
                    miss_q         <= '0;
                end else begin
                    mismatch_q     <= 1'b1;
                    sample_count_q <= sample_count_d;
                    err_count_q    <= err_count_d;
                    error_q        <= 1'b1;
                    expected_q     <= rot_exp_d;
                    miss_q         <= miss_d;
                    if (!error_q) begin
                        first_bad_q <= number;
                        first_exp_q <= expected_q;
                    end
                    if (miss_d == LOST_LIMIT) begin
                        state_q  <= LOST;
                        locked_q <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef NUMBER_CHECKER_LOG_EN
    // Simulation-only trace of mismatches, lock loss and resync
    always @(posedge clk) begin
        if (!reset && !load && valid) begin
            if (state_q == TRACK && !hit_d) begin
                $display("number_checker: mismatch sample %0d observed %h expected %h",
                         sample_count_q, number, expected_q);
                if (miss_d == LOST_LIMIT)
                    $display("number_checker: entering LOST after %0d misses", LOST_N);
            end else if (state_q == LOST) begin
                $display("number_checker: resync on %h", number);
            end
        end
    end
`endif

    assign expected     = expected_q;
    assign match        = match_q;
    assign mismatch     = mismatch_q;
    assign error        = error_q;
    assign locked       = locked_q;
    assign err_count    = err_count_q;
    assign sample_count = sample_count_q;
    assign first_bad    = first_bad_q;
    assign first_exp    = first_exp_q;

endmodule

// File: tb/tb_number_checker.sv
// Directed testbench for number_checker. A second instance with CNT_W=2 and
// LOST_N=7 shares the stimulus so that counter saturation can be observed.
module tb_number_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] number = '0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;

    logic [7:0]  expected, first_bad, first_exp;
    logic        match, mismatch, error, locked;
    logic [15:0] err_count, sample_count;

    logic [7:0]  expected2, first_bad2, first_exp2;
    logic        match2, mismatch2, error2, locked2;
    logic [1:0]  err_count2, sample_count2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    number_checker #(.WIDTH(8), .CNT_W(16), .LOST_N(3)) dut (
        .clk(clk), .reset(reset), .valid(valid), .number(number), .dir(dir),
        .load(load), .load_value(load_value), .expected(expected), .match(match),
        .mismatch(mismatch), .error(error), .locked(locked), .err_count(err_count),
        .sample_count(sample_count), .first_bad(first_bad), .first_exp(first_exp)
    );

    number_checker #(.WIDTH(8), .CNT_W(2), .LOST_N(7)) dut_sat (
        .clk(clk), .reset(reset), .valid(valid), .number(number), .dir(dir),
        .load(load), .load_value(load_value), .expected(expected2), .match(match2),
        .mismatch(mismatch2), .error(error2), .locked(locked2), .err_count(err_count2),
        .sample_count(sample_count2), .first_bad(first_bad2), .first_exp(first_exp2)
    );

    // Apply one cycle of stimulus and sample outputs 1 time unit after the edge
    task automatic drive(input logic v, input logic [7:0] n, input logic d,
                         input logic ld, input logic [7:0] lv);
        valid = v; number = n; dir = d; load = ld; load_value = lv;
        @(posedge clk);
        #1;
        valid = 1'b0; load = 1'b0;
        $display("cycle: valid=%0b number=%h dir=%0b load=%0b lv=%h -> exp=%h m=%0b mm=%0b lk=%0b ec=%0d sc=%0d",
                 v, n, d, ld, lv, expected, match, mismatch, locked, err_count, sample_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (expected !== 8'h00) begin $display("FAIL reset_expected got %h want %h", expected, 8'h00); n_bad++; end
        n_vec++; if ({match, mismatch, error, locked} !== 4'b0000) begin $display("FAIL reset_flags got %b want %b", {match, mismatch, error, locked}, 4'b0000); n_bad++; end
        n_vec++; if ({err_count, sample_count} !== 32'h0) begin $display("FAIL reset_counts got %h want %h", {err_count, sample_count}, 32'h0); n_bad++; end
        n_vec++; if ({first_bad, first_exp} !== 16'h0) begin $display("FAIL reset_captures got %h want %h", {first_bad, first_exp}, 16'h0); n_bad++; end
    endtask

    task automatic test_track_left();
        do_reset();
        drive(1, 8'h01, 1, 0, 8'h00);
        n_vec++; if (expected !== 8'h02) begin $display("FAIL seed_expected got %h want %h", expected, 8'h02); n_bad++; end
        n_vec++; if ({match, mismatch, locked} !== 3'b001) begin $display("FAIL seed_flags got %b want %b", {match, mismatch, locked}, 3'b001); n_bad++; end
        n_vec++; if (sample_count !== 16'd0) begin $display("FAIL seed_count got %0d want %0d", sample_count, 0); n_bad++; end
        drive(1, 8'h02, 1, 0, 8'h00);
        n_vec++; if (match !== 1'b1) begin $display("FAIL match_pulse1 got %b want %b", match, 1'b1); n_bad++; end
        drive(1, 8'h04, 1, 0, 8'h00);
        n_vec++; if (match !== 1'b1) begin $display("FAIL match_pulse2 got %b want %b", match, 1'b1); n_bad++; end
        drive(1, 8'h08, 1, 0, 8'h00);
        n_vec++; if (match !== 1'b1) begin $display("FAIL match_pulse3 got %b want %b", match, 1'b1); n_bad++; end
        n_vec++; if (sample_count !== 16'd3) begin $display("FAIL track_samples got %0d want %0d", sample_count, 3); n_bad++; end
        n_vec++; if (err_count !== 16'd0) begin $display("FAIL track_errors got %0d want %0d", err_count, 0); n_bad++; end
        n_vec++; if (locked !== 1'b1) begin $display("FAIL track_locked got %b want %b", locked, 1'b1); n_bad++; end
        n_vec++; if (expected !== 8'h10) begin $display("FAIL track_expected got %h want %h", expected, 8'h10); n_bad++; end
        drive(0, 8'h55, 1, 0, 8'h00);
        n_vec++; if ({match, expected} !== {1'b0, 8'h10}) begin $display("FAIL idle_cycle got %h want %h", {match, expected}, {1'b0, 8'h10}); n_bad++; end
    endtask

    task automatic test_mismatch_right();
        do_reset();
        drive(1, 8'h80, 0, 0, 8'h00);
        n_vec++; if (expected !== 8'h40) begin $display("FAIL right_seed got %h want %h", expected, 8'h40); n_bad++; end
        drive(1, 8'h40, 0, 0, 8'h00);
        n_vec++; if (match !== 1'b1) begin $display("FAIL right_match got %b want %b", match, 1'b1); n_bad++; end
        drive(1, 8'h21, 0, 0, 8'h00);
        n_vec++; if ({match, mismatch, error} !== 3'b011) begin $display("FAIL miss_flags got %b want %b", {match, mismatch, error}, 3'b011); n_bad++; end
        n_vec++; if (first_bad !== 8'h21) begin $display("FAIL first_bad got %h want %h", first_bad, 8'h21); n_bad++; end
        n_vec++; if (first_exp !== 8'h20) begin $display("FAIL first_exp got %h want %h", first_exp, 8'h20); n_bad++; end
        n_vec++; if (expected !== 8'h10) begin $display("FAIL freerun_expected got %h want %h", expected, 8'h10); n_bad++; end
        drive(1, 8'h10, 0, 0, 8'h00);
        n_vec++; if ({match, mismatch} !== 2'b10) begin $display("FAIL freerun_match got %b want %b", {match, mismatch}, 2'b10); n_bad++; end
        n_vec++; if (err_count !== 16'd1) begin $display("FAIL right_errors got %0d want %0d", err_count, 1); n_bad++; end
        n_vec++; if (sample_count !== 16'd3) begin $display("FAIL right_samples got %0d want %0d", sample_count, 3); n_bad++; end
        n_vec++; if (error !== 1'b1) begin $display("FAIL error_sticky got %b want %b", error, 1'b1); n_bad++; end
    endtask

    task automatic test_lost_resync();
        do_reset();
        drive(1, 8'h01, 1, 0, 8'h00);
        drive(1, 8'hFF, 1, 0, 8'h00);
        n_vec++; if ({mismatch, locked} !== 2'b11) begin $display("FAIL miss1 got %b want %b", {mismatch, locked}, 2'b11); n_bad++; end
        drive(1, 8'hFF, 1, 0, 8'h00);
        n_vec++; if ({mismatch, locked} !== 2'b11) begin $display("FAIL miss2 got %b want %b", {mismatch, locked}, 2'b11); n_bad++; end
        drive(1, 8'hFF, 1, 0, 8'h00);
        n_vec++; if ({mismatch, locked} !== 2'b10) begin $display("FAIL miss3_lost got %b want %b", {mismatch, locked}, 2'b10); n_bad++; end
        n_vec++; if (err_count !== 16'd3) begin $display("FAIL lost_errors got %0d want %0d", err_count, 3); n_bad++; end
        n_vec++; if ({first_bad, first_exp} !== {8'hFF, 8'h02}) begin $display("FAIL lost_captures got %h want %h", {first_bad, first_exp}, {8'hFF, 8'h02}); n_bad++; end
        drive(1, 8'h11, 1, 0, 8'h00);
        n_vec++; if (expected !== 8'h22) begin $display("FAIL resync_expected got %h want %h", expected, 8'h22); n_bad++; end
        n_vec++; if ({match, mismatch, locked} !== 3'b001) begin $display("FAIL resync_flags got %b want %b", {match, mismatch, locked}, 3'b001); n_bad++; end
        n_vec++; if ({err_count, sample_count} !== {16'd3, 16'd3}) begin $display("FAIL resync_counts got %h want %h", {err_count, sample_count}, {16'd3, 16'd3}); n_bad++; end
        drive(1, 8'h22, 1, 0, 8'h00);
        n_vec++; if (match !== 1'b1) begin $display("FAIL resync_track got %b want %b", match, 1'b1); n_bad++; end
    endtask

    task automatic test_load();
        do_reset();
        drive(0, 8'h00, 1, 1, 8'h5A);
        n_vec++; if ({locked, expected} !== {1'b1, 8'h5A}) begin $display("FAIL load_idle got %h want %h", {locked, expected}, {1'b1, 8'h5A}); n_bad++; end
        do_reset();
        drive(1, 8'h01, 1, 0, 8'h00);
        drive(1, 8'h02, 1, 0, 8'h00);
        drive(1, 8'h00, 1, 1, 8'hAA);
        n_vec++; if (expected !== 8'hAA) begin $display("FAIL load_expected got %h want %h", expected, 8'hAA); n_bad++; end
        n_vec++; if ({match, mismatch, error} !== 3'b000) begin $display("FAIL load_nocompare got %b want %b", {match, mismatch, error}, 3'b000); n_bad++; end
        n_vec++; if (sample_count !== 16'd1) begin $display("FAIL load_samples got %0d want %0d", sample_count, 1); n_bad++; end
        drive(1, 8'hAA, 1, 0, 8'h00);
        n_vec++; if ({match, expected} !== {1'b1, 8'h55}) begin $display("FAIL load_followup got %h want %h", {match, expected}, {1'b1, 8'h55}); n_bad++; end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1, 8'h01, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'hFF, 1, 0, 8'h00);
        end
        n_vec++; if (err_count2 !== 2'b11) begin $display("FAIL sat_errors got %b want %b", err_count2, 2'b11); n_bad++; end
        n_vec++; if (sample_count2 !== 2'b11) begin $display("FAIL sat_samples got %b want %b", sample_count2, 2'b11); n_bad++; end
        n_vec++; if ({mismatch2, locked2} !== 2'b11) begin $display("FAIL sat_flags got %b want %b", {mismatch2, locked2}, 2'b11); n_bad++; end
        // Main instance lost lock after three misses, so the fourth sample reseeds it
        n_vec++; if ({locked, mismatch, err_count} !== {2'b10, 16'd3}) begin $display("FAIL sat_main got %h want %h", {locked, mismatch, err_count}, {2'b10, 16'd3}); n_bad++; end
    endtask

    task automatic test_back_to_back_reset();
        do_reset();
        drive(1, 8'h01, 1, 0, 8'h00);
        drive(1, 8'h02, 1, 0, 8'h00);
        drive(1, 8'h04, 1, 0, 8'h00);
        n_vec++; if (match !== 1'b1) begin $display("FAIL b2b_match got %b want %b", match, 1'b1); n_bad++; end
        drive(1, 8'h33, 1, 0, 8'h00);
        n_vec++; if ({match, mismatch, error} !== 3'b011) begin $display("FAIL b2b_mismatch got %b want %b", {match, mismatch, error}, 3'b011); n_bad++; end
        reset = 1'b1;
        drive(1, 8'h10, 1, 1, 8'hC3);
        reset = 1'b0;
        n_vec++; if ({expected, first_bad, first_exp} !== 24'h0) begin $display("FAIL rst_values got %h want %h", {expected, first_bad, first_exp}, 24'h0); n_bad++; end
        n_vec++; if ({match, mismatch, error, locked} !== 4'b0000) begin $display("FAIL rst_flags got %b want %b", {match, mismatch, error, locked}, 4'b0000); n_bad++; end
        n_vec++; if ({err_count, sample_count} !== 32'h0) begin $display("FAIL rst_counts got %h want %h", {err_count, sample_count}, 32'h0); n_bad++; end
        drive(1, 8'h40, 1, 0, 8'h00);
        n_vec++; if ({match, locked, expected} !== {2'b01, 8'h80}) begin $display("FAIL rst_reseed got %h want %h", {match, locked, expected}, {2'b01, 8'h80}); n_bad++; end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_track_left();
        test_mismatch_right();
        test_lost_resync();
        test_load();
        test_saturate();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
